// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: mode encoding and default timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int TICK_DIV_DEF   = 100;
    localparam int DEB_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_t;

    // The prescaler advances and count ticks are allowed only in these modes.
    function automatic logic is_running(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, rising-edge press pulse.
// Latency: first high raw sample at edge k -> press high in the cycle after edge k+2+DEB_CYCLES.
// Backpressure: none; press is a free-running 1-cycle strobe, releases produce nothing.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            // Once DEB_CYCLES disagreeing samples have been seen, commit the new level.
            if (cnt == CW'(DEB_CYCLES)) begin
                level <= ~level;
                cnt   <= '0;
            end else if (sync2 != level) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, IDLE/RUN/LAP/PAUSE mode FSM, count-enable prescaler.
// Latency: button press -> mode change 1 edge after the debounced pulse; cnt_clr 1 cycle after decision.
// Backpressure: none; cnt_en and cnt_clr are 1-cycle strobes the counter must accept.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int PRE_W      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_clr,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic       running,
    output logic [1:0] state
);

    sw_state_t  cur_st;
    sw_state_t  nxt_st;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic       clr_q;
    logic       clr_nxt;
    logic       ss_press;
    logic       lc_press;
    logic       pre_wrap;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_stop),
        .press (ss_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lc (
        .clk   (clk),
        .rst   (rst),
        .btn   (lap_clr),
        .press (lc_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st <= ST_IDLE;
            pre    <= '0;
            clr_q  <= 1'b0;
        end else begin
            cur_st <= nxt_st;
            pre    <= pre_nxt;
            clr_q  <= clr_nxt;
        end
    end

    // start_stop has priority; a simultaneous lap_clr press is dropped.
    always_comb begin
        nxt_st  = cur_st;
        clr_nxt = 1'b0;
        case (cur_st)
            ST_IDLE: begin
                if (ss_press) begin
                    nxt_st = ST_RUN;
                end else if (lc_press) begin
                    clr_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (ss_press) begin
                    nxt_st = ST_PAUSE;
                end else if (lc_press) begin
                    nxt_st = ST_LAP;
                end
            end
            ST_LAP: begin
                if (ss_press) begin
                    nxt_st = ST_PAUSE;
                end else if (lc_press) begin
                    nxt_st = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (ss_press) begin
                    nxt_st = ST_RUN;
                end else if (lc_press) begin
                    nxt_st  = ST_IDLE;
                    clr_nxt = 1'b1;
                end
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    assign pre_wrap = (pre == PRE_W'(TICK_DIV - 1));

    // Prescaler follows the current mode: PAUSE keeps the partial second for resume.
    always_comb begin
        pre_nxt = pre;
        if (is_running(cur_st)) begin
            pre_nxt = pre_wrap ? '0 : pre + PRE_W'(1);
        end else if (cur_st == ST_IDLE) begin
            pre_nxt = '0;
        end
    end

    assign running   = is_running(cur_st);
    assign cnt_en    = running & pre_wrap;
    assign cnt_clr   = clr_q;
    assign disp_hold = (cur_st == ST_LAP);
    assign state     = cur_st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl against a mode-table reference model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TD  = 10;
    localparam int DEB = DEB_CYCLES_DEF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap_clr = 1'b0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       disp_hold;
    logic       running;
    logic [1:0] state;

    int vec  = 0;
    int miss = 0;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB), .PRE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap_clr    (lap_clr),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .disp_hold  (disp_hold),
        .running    (running),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode transitions as lookup tables indexed by current mode (0..3).
    int  ss_tbl [4] = '{1, 3, 3, 1};
    int  lc_tbl [4] = '{0, 2, 1, 0};
    int  m_mode  = 0;
    int  m_phase = 0;   // RUN/LAP cycles elapsed since IDLE, modulo TD
    bit  m_clr   = 1'b0;
    bit  m_press [2];
    bit  m_lvl   [2];
    bit  m_due   [2];
    bit  m_h1    [2];
    bit  m_h2    [2];
    int  m_streak[2];

    always @(posedge clk or negedge rst) begin
        bit ss, lc, raw;
        if (!rst) begin
            m_mode = 0; m_phase = 0; m_clr = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_press[b] = 1'b0; m_lvl[b] = 1'b0; m_due[b] = 1'b0;
                m_h1[b] = 1'b0; m_h2[b] = 1'b0; m_streak[b] = 0;
            end
        end else begin
            ss = m_press[0];
            lc = m_press[1];
            if (m_mode == 1 || m_mode == 2) m_phase = (m_phase + 1) % TD;
            else if (m_mode == 0)           m_phase = 0;
            m_clr = lc && !ss && (m_mode == 0 || m_mode == 3);
            if (ss)      m_mode = ss_tbl[m_mode];
            else if (lc) m_mode = lc_tbl[m_mode];
            for (int b = 0; b < 2; b++) begin
                raw = (b == 0) ? start_stop : lap_clr;
                m_press[b] = 1'b0;
                if (m_due[b]) begin
                    m_lvl[b] = !m_lvl[b];
                    m_due[b] = 1'b0;
                    m_streak[b] = 0;
                    m_press[b] = m_lvl[b];
                end else if (m_h2[b] != m_lvl[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == DEB) m_due[b] = 1'b1;
                end else begin
                    m_streak[b] = 0;
                end
                m_h2[b] = m_h1[b];
                m_h1[b] = raw;
            end
        end
    end

    always @(negedge clk) begin
        chk("state", state, m_mode);
        chk("cnt_en", cnt_en, ((m_mode == 1 || m_mode == 2) && m_phase == TD - 1));
        chk("cnt_clr", cnt_clr, m_clr);
        chk("disp_hold", disp_hold, (m_mode == 2));
        chk("running", running, (m_mode == 1 || m_mode == 2));
    end

    // Directed-phase rule: every tick comes exactly TD running cycles after the previous one.
    bit dir_on = 1'b1;
    int rc = 0;
    always @(negedge clk) begin
        if (dir_on) begin
            if (state == 2'd0) rc = 0;
            else if (state == 2'd1 || state == 2'd2) rc++;
            if (cnt_en) begin
                chk("tick_spacing", rc, TD);
                rc = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input bit b_ss, input bit b_lc, input int n);
        start_stop = b_ss;
        lap_clr    = b_lc;
        cyc(n);
    endtask

    task automatic press_btn(input bit b_ss, input bit b_lc);
        hold(b_ss, b_lc, 8);
        hold(1'b0, 1'b0, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, ticks, first, cnt, seen_lap;
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start_stop = 1'($urandom);
            lap_clr    = 1'($urandom);
            cyc(1);
        end
        chk("rst_state", state, 0);
        chk("rst_running", running, 0);
        #1 rst = 1'b1;
        hold(1'b0, 1'b0, 12);
        chk("idle_after_rst", state, 0);

        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 12);
        chk("glitch_idle", state, 0);

        // Start: press pulse 6 cycles after first sample, RUN on the next edge.
        start_stop = 1'b1;
        found = 0; ticks = 0; first = 0;
        for (int t = 1; t <= 57; t++) begin
            cyc(1);
            if (t == 12) start_stop = 1'b0;
            if (found == 0 && state == 2'd1) found = t;
            if (cnt_en) begin
                ticks++;
                if (first == 0) first = t;
            end
        end
        chk("run_entry_cycle", found, 8);
        chk("first_tick_cycle", first, 17);
        chk("ticks_in_50", ticks, 5);

        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 12);
        chk("glitch_run", state, 1);

        press_btn(1'b0, 1'b1);
        chk("lap_state", state, 2);
        chk("lap_hold", disp_hold, 1);
        press_btn(1'b0, 1'b1);
        chk("unlap_state", state, 1);
        chk("unlap_hold", disp_hold, 0);

        press_btn(1'b1, 1'b0);
        chk("pause_state", state, 3);
        cnt = 0;
        for (int t = 0; t < 30; t++) begin
            cyc(1);
            if (cnt_en) cnt++;
        end
        chk("pause_no_tick", cnt, 0);
        press_btn(1'b1, 1'b0);
        hold(1'b0, 1'b0, 20);
        chk("resume_state", state, 1);

        press_btn(1'b1, 1'b0);
        chk("pause2_state", state, 3);
        lap_clr = 1'b1;
        cnt = 0;
        for (int t = 1; t <= 20; t++) begin
            cyc(1);
            if (t == 8) lap_clr = 1'b0;
            if (cnt_clr) cnt++;
        end
        chk("clr_pulses", cnt, 1);
        chk("clr_state", state, 0);

        press_btn(1'b1, 1'b0);
        hold(1'b0, 1'b0, 5);
        chk("rerun_state", state, 1);
        start_stop = 1'b1; lap_clr = 1'b1;
        cnt = 0; seen_lap = 0;
        for (int t = 1; t <= 15; t++) begin
            cyc(1);
            if (t == 8) begin start_stop = 1'b0; lap_clr = 1'b0; end
            if (state == 2'd2) seen_lap = 1;
            if (cnt_clr) cnt++;
        end
        hold(1'b0, 1'b0, 5);
        chk("both_state", state, 3);
        chk("both_no_lap", seen_lap, 0);
        chk("both_no_clr", cnt, 0);

        press_btn(1'b1, 1'b0);
        hold(1'b0, 1'b0, 13);
        chk("pre_reset_state", state, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_cnt_en", cnt_en, 0);
        chk("async_rst_hold", disp_hold, 0);
        chk("async_rst_clr", cnt_clr, 0);
        cyc(2);
        #1 rst = 1'b1;
        cyc(2);

        dir_on = 1'b0;
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 59) == 0) begin
                #1 rst = 1'b0;
                cyc(2);
                #1 rst = 1'b1;
            end
            hold(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom_range(1, 10));
        end
        hold(1'b0, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
